// File: rtl/mem_stage_pkg.sv
// Shared encodings for the memory-access stage: op codes, exception codes,
// bus polarities and the bus FSM state type.
package mem_stage_pkg;

   typedef enum logic [1:0] {
      MEM_OP_NOP = 2'd0,
      MEM_OP_LDW = 2'd1,
      MEM_OP_STW = 2'd2
   } mem_op_t;

   localparam logic [2:0] ISA_EXP_NO_EXP     = 3'd0;
   localparam logic [2:0] ISA_EXP_MISS_ALIGN = 3'd4;

   localparam logic READ     = 1'b1;
   localparam logic WRITE    = 1'b0;
   localparam logic ENABLE_  = 1'b0;
   localparam logic DISABLE_ = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REQ    = 2'd1,
      ST_ACCESS = 2'd2,
      ST_STALL  = 2'd3
   } bus_state_t;

endpackage

// File: rtl/mem_stage_bus_if.sv
// Bus handshake FSM: request/grant arbitration, one-cycle address strobe,
// wait for slave ready, and hold of load data while the pipeline is stalled.
//
// state     | meaning
// ST_IDLE   | no transaction; a new access raises bus_req_
// ST_REQ    | waiting for grant; strobe and address issued on grant
// ST_ACCESS | strobe done, waiting for bus_rdy_
// ST_STALL  | transaction finished, load data held until stall drops
module mem_stage_bus_if
   import mem_stage_pkg::*;
#(
   parameter int WORD_ADDR_W = 30,
   parameter int WORD_DATA_W = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic                   access,
   input  logic                   rw,
   input  logic [WORD_ADDR_W-1:0] addr,
   input  logic [WORD_DATA_W-1:0] wr_data,
   output logic                   busy,
   output logic [WORD_DATA_W-1:0] rd_data,
   output logic                   bus_req_,
   input  logic                   bus_grnt_,
   output logic                   bus_as_,
   output logic                   bus_rw,
   output logic [WORD_ADDR_W-1:0] bus_addr,
   output logic [WORD_DATA_W-1:0] bus_wr_data,
   input  logic [WORD_DATA_W-1:0] bus_rd_data,
   input  logic                   bus_rdy_
);

   bus_state_t             state, state_nxt;
   logic                   req_nxt, as_nxt, rw_nxt;
   logic [WORD_ADDR_W-1:0] addr_nxt;
   logic [WORD_DATA_W-1:0] wdata_nxt, rd_buf, rd_buf_nxt;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_IDLE;
         bus_req_    <= DISABLE_;
         bus_as_     <= DISABLE_;
         bus_rw      <= READ;
         bus_addr    <= '0;
         bus_wr_data <= '0;
         rd_buf      <= '0;
      end else begin
         state       <= state_nxt;
         bus_req_    <= req_nxt;
         bus_as_     <= as_nxt;
         bus_rw      <= rw_nxt;
         bus_addr    <= addr_nxt;
         bus_wr_data <= wdata_nxt;
         rd_buf      <= rd_buf_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      busy       = 1'b0;
      rd_data    = rd_buf;
      req_nxt    = bus_req_;
      as_nxt     = DISABLE_;
      rw_nxt     = bus_rw;
      addr_nxt   = bus_addr;
      wdata_nxt  = bus_wr_data;
      rd_buf_nxt = rd_buf;
      case (state)
         ST_IDLE: begin
            if (access) begin
               busy      = 1'b1;
               req_nxt   = ENABLE_;
               state_nxt = ST_REQ;
            end
         end
         ST_REQ: begin
            busy = 1'b1;
            if (bus_grnt_ == ENABLE_) begin
               as_nxt    = ENABLE_;
               rw_nxt    = rw;
               addr_nxt  = addr;
               wdata_nxt = wr_data;
               state_nxt = ST_ACCESS;
            end
         end
         ST_ACCESS: begin
            if (bus_rdy_ == ENABLE_) begin
               // data goes straight through this cycle and is kept for a stall
               rd_data    = bus_rd_data;
               rd_buf_nxt = bus_rd_data;
               req_nxt    = DISABLE_;
               rw_nxt     = READ;
               addr_nxt   = '0;
               wdata_nxt  = '0;
               state_nxt  = stall ? ST_STALL : ST_IDLE;
            end else begin
               busy = 1'b1;
            end
         end
         ST_STALL: begin
            if (!stall) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: alignment check, bus access through the
// handshake FSM, and the MEM/WB pipeline register.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int WORD_ADDR_W = 30,
   parameter int WORD_DATA_W = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic                   flush,
   output logic                   busy,
   input  logic [WORD_ADDR_W-1:0] ex_pc,
   input  logic                   ex_en,
   input  logic                   ex_br_flag,
   input  logic [1:0]             ex_ctrl_op,
   input  logic [4:0]             ex_dst_addr,
   input  logic                   ex_gpr_we_,
   input  logic [2:0]             ex_exp_code,
   input  logic [1:0]             ex_mem_op,
   input  logic [WORD_DATA_W-1:0] ex_mem_wr_data,
   input  logic [WORD_DATA_W-1:0] ex_out,
   output logic                   bus_req_,
   input  logic                   bus_grnt_,
   output logic                   bus_as_,
   output logic                   bus_rw,
   output logic [WORD_ADDR_W-1:0] bus_addr,
   output logic [WORD_DATA_W-1:0] bus_wr_data,
   input  logic [WORD_DATA_W-1:0] bus_rd_data,
   input  logic                   bus_rdy_,
   output logic [WORD_ADDR_W-1:0] mem_pc,
   output logic                   mem_en,
   output logic                   mem_br_flag,
   output logic [1:0]             mem_ctrl_op,
   output logic [4:0]             mem_dst_addr,
   output logic                   mem_gpr_we_,
   output logic [2:0]             mem_exp_code,
   output logic [WORD_DATA_W-1:0] mem_out
);

   logic                   is_mem_op, is_ldw, access, miss_align, rw;
   logic [WORD_DATA_W-1:0] rd_data;

   // an incoming exception suppresses both the access and the alignment check
   always_comb begin
      is_mem_op  = ex_en && (ex_exp_code == ISA_EXP_NO_EXP) &&
                   ((ex_mem_op == MEM_OP_LDW) || (ex_mem_op == MEM_OP_STW));
      is_ldw     = ex_mem_op == MEM_OP_LDW;
      access     = is_mem_op && (ex_out[1:0] == 2'b00) && !flush;
      miss_align = is_mem_op && (ex_out[1:0] != 2'b00);
      rw         = is_ldw ? READ : WRITE;
   end

   mem_stage_bus_if #(
      .WORD_ADDR_W (WORD_ADDR_W),
      .WORD_DATA_W (WORD_DATA_W)
   ) u_bus_if (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .access      (access),
      .rw          (rw),
      .addr        (ex_out[WORD_DATA_W-1:2]),
      .wr_data     (ex_mem_wr_data),
      .busy        (busy),
      .rd_data     (rd_data),
      .bus_req_    (bus_req_),
      .bus_grnt_   (bus_grnt_),
      .bus_as_     (bus_as_),
      .bus_rw      (bus_rw),
      .bus_addr    (bus_addr),
      .bus_wr_data (bus_wr_data),
      .bus_rd_data (bus_rd_data),
      .bus_rdy_    (bus_rdy_)
   );

   always_ff @(posedge clk) begin
      if (reset || (!stall && flush)) begin
         mem_pc       <= '0;
         mem_en       <= 1'b0;
         mem_br_flag  <= 1'b0;
         mem_ctrl_op  <= '0;
         mem_dst_addr <= '0;
         mem_gpr_we_  <= DISABLE_;
         mem_exp_code <= ISA_EXP_NO_EXP;
         mem_out      <= '0;
      end else if (!stall) begin
         mem_pc       <= ex_pc;
         mem_en       <= ex_en;
         mem_br_flag  <= ex_br_flag;
         mem_ctrl_op  <= ex_ctrl_op;
         mem_dst_addr <= ex_dst_addr;
         mem_gpr_we_  <= miss_align ? DISABLE_ : ex_gpr_we_;
         mem_exp_code <= miss_align ? ISA_EXP_MISS_ALIGN : ex_exp_code;
         mem_out      <= (access && is_ldw) ? rd_data : ex_out;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage; the control unit is modelled as stall = busy | ext_stall.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset, stall, flush, busy, ext_stall;
   logic [29:0] ex_pc;
   logic        ex_en, ex_br_flag, ex_gpr_we_;
   logic [1:0]  ex_ctrl_op, ex_mem_op;
   logic [4:0]  ex_dst_addr;
   logic [2:0]  ex_exp_code;
   logic [31:0] ex_mem_wr_data, ex_out;
   logic        bus_req_, bus_grnt_, bus_as_, bus_rw, bus_rdy_;
   logic [29:0] bus_addr;
   logic [31:0] bus_wr_data, bus_rd_data;
   logic [29:0] mem_pc;
   logic        mem_en, mem_br_flag, mem_gpr_we_;
   logic [1:0]  mem_ctrl_op;
   logic [4:0]  mem_dst_addr;
   logic [2:0]  mem_exp_code;
   logic [31:0] mem_out;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;
   assign stall = busy | ext_stall;

   mem_stage dut (
      .clk(clk), .reset(reset), .stall(stall), .flush(flush), .busy(busy),
      .ex_pc(ex_pc), .ex_en(ex_en), .ex_br_flag(ex_br_flag), .ex_ctrl_op(ex_ctrl_op),
      .ex_dst_addr(ex_dst_addr), .ex_gpr_we_(ex_gpr_we_), .ex_exp_code(ex_exp_code),
      .ex_mem_op(ex_mem_op), .ex_mem_wr_data(ex_mem_wr_data), .ex_out(ex_out),
      .bus_req_(bus_req_), .bus_grnt_(bus_grnt_), .bus_as_(bus_as_), .bus_rw(bus_rw),
      .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_rd_data(bus_rd_data),
      .bus_rdy_(bus_rdy_), .mem_pc(mem_pc), .mem_en(mem_en), .mem_br_flag(mem_br_flag),
      .mem_ctrl_op(mem_ctrl_op), .mem_dst_addr(mem_dst_addr), .mem_gpr_we_(mem_gpr_we_),
      .mem_exp_code(mem_exp_code), .mem_out(mem_out)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_nop(input logic [31:0] out);
      ex_pc = '0; ex_en = 1'b0; ex_br_flag = 1'b0; ex_ctrl_op = '0; ex_dst_addr = '0;
      ex_gpr_we_ = 1'b1; ex_exp_code = '0; ex_mem_op = 2'd0; ex_mem_wr_data = '0; ex_out = out;
   endtask

   task automatic set_op(input logic [1:0] op, input logic [31:0] out, input logic [31:0] wd,
                         input logic [4:0] dst, input logic we_);
      ex_pc = 30'h20; ex_en = 1'b1; ex_br_flag = 1'b0; ex_ctrl_op = '0; ex_dst_addr = dst;
      ex_gpr_we_ = we_; ex_exp_code = '0; ex_mem_op = op; ex_mem_wr_data = wd; ex_out = out;
   endtask

   // Slave model: grants after `delay` REQ cycles, answers ready while the strobe is visible.
   task automatic run_access(input int delay, output int busy_n, output int as_n,
                             output logic [29:0] a, output logic rw, output logic [31:0] wd,
                             output logic done);
      int k = 0;
      busy_n = 0; as_n = 0; a = '0; rw = 1'b1; wd = '0; done = 1'b0;
      for (int i = 0; i < 30 && !done; i++) begin
         if (bus_req_ == 1'b0 && bus_as_ == 1'b1) begin
            bus_grnt_ = (k >= delay) ? 1'b0 : 1'b1;
            k++;
         end else begin
            bus_grnt_ = 1'b1;
         end
         bus_rdy_ = bus_as_;
         #1;
         if (busy) busy_n++;
         if (!bus_as_) begin as_n++; a = bus_addr; rw = bus_rw; wd = bus_wr_data; end
         if (!busy && busy_n > 0) done = 1'b1;
         else step();
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; ext_stall = 1'b0; set_nop(32'h0);
      bus_grnt_ = 1'b1; bus_rdy_ = 1'b1; bus_rd_data = '0;
      step(); step();
      reset = 1'b0;
      #1;
      total++;
      if ({bus_req_, bus_as_, bus_rw, busy, mem_en, mem_gpr_we_} !== 6'b111001) begin
         bad++; $display("FAIL reset_ctrl got=%b want=111001",
                         {bus_req_, bus_as_, bus_rw, busy, mem_en, mem_gpr_we_});
      end
      total++;
      if ({bus_addr, bus_wr_data, mem_out, mem_pc, mem_exp_code, mem_dst_addr} !== '0) begin
         bad++; $display("FAIL reset_data addr=%h wd=%h out=%h pc=%h exp=%h dst=%h",
                         bus_addr, bus_wr_data, mem_out, mem_pc, mem_exp_code, mem_dst_addr);
      end
   endtask

   task automatic test_alu();
      step();
      set_op(2'd0, 32'h0000_1234, 32'h0, 5'd3, 1'b0);
      ex_pc = 30'h10; ex_br_flag = 1'b1; ex_ctrl_op = 2'd2;
      #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL alu_busy got=%b want=0", busy); end
      step();
      total++;
      if ({mem_out, mem_en, mem_gpr_we_, mem_dst_addr, bus_req_} !== {32'h1234, 1'b1, 1'b0, 5'd3, 1'b1}) begin
         bad++; $display("FAIL alu_latch out=%h en=%b we_=%b dst=%0d req_=%b want 1234/1/0/3/1",
                         mem_out, mem_en, mem_gpr_we_, mem_dst_addr, bus_req_);
      end
      total++;
      if ({mem_pc, mem_br_flag, mem_ctrl_op} !== {30'h10, 1'b1, 2'd2}) begin
         bad++; $display("FAIL alu_fields pc=%h br=%b ctrl=%0d want 10/1/2",
                         mem_pc, mem_br_flag, mem_ctrl_op);
      end
   endtask

   task automatic test_back_to_back();
      set_op(2'd0, 32'h1111, 32'h0, 5'd7, 1'b0);
      step();
      total++;
      if ({mem_out, mem_dst_addr} !== {32'h1111, 5'd7}) begin
         bad++; $display("FAIL b2b_first out=%h dst=%0d want 1111/7", mem_out, mem_dst_addr);
      end
      set_op(2'd0, 32'h2222, 32'h0, 5'd8, 1'b0);
      step();
      total++;
      if ({mem_out, mem_dst_addr} !== {32'h2222, 5'd8}) begin
         bad++; $display("FAIL b2b_second out=%h dst=%0d want 2222/8", mem_out, mem_dst_addr);
      end
   endtask

   task automatic test_ldw();
      int bn, an; logic [29:0] a; logic rw; logic [31:0] wd; logic done;
      step();
      bus_rd_data = 32'hDEAD_BEEF;
      set_op(2'd1, 32'h100, 32'h0, 5'd5, 1'b0);
      run_access(0, bn, an, a, rw, wd, done);
      total++;
      if (!done) begin bad++; $display("FAIL ldw_timeout done=%b want=1", done); end
      step();
      bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; set_nop(32'h0);
      total++;
      if ({bn, an} !== {32'd2, 32'd1}) begin
         bad++; $display("FAIL ldw_cycles busy=%0d strobes=%0d want 2/1", bn, an);
      end
      total++;
      if ({a, rw} !== {30'h40, 1'b1}) begin
         bad++; $display("FAIL ldw_bus addr=%h rw=%b want 40/1", a, rw);
      end
      total++;
      if ({mem_out, mem_dst_addr, mem_gpr_we_, mem_exp_code, bus_req_} !== {32'hDEAD_BEEF, 5'd5, 1'b0, 3'd0, 1'b1}) begin
         bad++; $display("FAIL ldw_result out=%h dst=%0d we_=%b exp=%0d req_=%b want deadbeef/5/0/0/1",
                         mem_out, mem_dst_addr, mem_gpr_we_, mem_exp_code, bus_req_);
      end
   endtask

   task automatic test_stw();
      int bn, an; logic [29:0] a; logic rw; logic [31:0] wd; logic done;
      step();
      set_op(2'd2, 32'h200, 32'hA5A5_A5A5, 5'd0, 1'b1);
      run_access(3, bn, an, a, rw, wd, done);
      total++;
      if (!done) begin bad++; $display("FAIL stw_timeout done=%b want=1", done); end
      step();
      bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; set_nop(32'h0);
      total++;
      if ({bn, an} !== {32'd5, 32'd1}) begin
         bad++; $display("FAIL stw_cycles busy=%0d strobes=%0d want 5/1", bn, an);
      end
      total++;
      if ({a, rw, wd} !== {30'h80, 1'b0, 32'hA5A5_A5A5}) begin
         bad++; $display("FAIL stw_bus addr=%h rw=%b wd=%h want 80/0/a5a5a5a5", a, rw, wd);
      end
      total++;
      if ({mem_out, mem_gpr_we_, bus_req_} !== {32'h200, 1'b1, 1'b1}) begin
         bad++; $display("FAIL stw_result out=%h we_=%b req_=%b want 200/1/1", mem_out, mem_gpr_we_, bus_req_);
      end
   endtask

   task automatic test_misalign();
      step();
      set_op(2'd1, 32'h102, 32'h0, 5'd9, 1'b0);
      #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL misalign_busy got=%b want=0", busy); end
      step();
      total++;
      if ({mem_exp_code, mem_gpr_we_, mem_out, bus_req_} !== {3'd4, 1'b1, 32'h102, 1'b1}) begin
         bad++; $display("FAIL misalign_result exp=%0d we_=%b out=%h req_=%b want 4/1/102/1",
                         mem_exp_code, mem_gpr_we_, mem_out, bus_req_);
      end
      ex_exp_code = 3'd3;
      step();
      total++;
      if ({mem_exp_code, bus_req_} !== {3'd3, 1'b1}) begin
         bad++; $display("FAIL misalign_priority exp=%0d req_=%b want 3/1", mem_exp_code, bus_req_);
      end
      set_nop(32'h0);
   endtask

   task automatic test_stall_complete();
      int bn, an; logic [29:0] a; logic rw; logic [31:0] wd; logic done;
      step();
      set_nop(32'h5555);
      step();
      bus_rd_data = 32'hDEAD_BEEF; ext_stall = 1'b1;
      set_op(2'd1, 32'h100, 32'h0, 5'd6, 1'b0);
      run_access(0, bn, an, a, rw, wd, done);
      total++;
      if (!done) begin bad++; $display("FAIL stall_timeout done=%b want=1", done); end
      step();
      bus_rdy_ = 1'b1; bus_grnt_ = 1'b1; bus_rd_data = 32'h0;
      #1;
      total++;
      if ({busy, bus_req_, mem_out} !== {1'b0, 1'b1, 32'h5555}) begin
         bad++; $display("FAIL stall_hold busy=%b req_=%b out=%h want 0/1/5555", busy, bus_req_, mem_out);
      end
      step();
      total++;
      if (mem_out !== 32'h5555) begin bad++; $display("FAIL stall_hold2 out=%h want 5555", mem_out); end
      step();
      ext_stall = 1'b0;
      step();
      set_nop(32'h0);
      total++;
      if ({mem_out, mem_dst_addr} !== {32'hDEAD_BEEF, 5'd6}) begin
         bad++; $display("FAIL stall_release out=%h dst=%0d want deadbeef/6", mem_out, mem_dst_addr);
      end
      step();
      total++;
      if ({bus_req_, busy} !== 2'b10) begin
         bad++; $display("FAIL stall_no_rerequest req_=%b busy=%b want 1/0", bus_req_, busy);
      end
   endtask

   task automatic test_flush();
      step();
      flush = 1'b1;
      set_op(2'd1, 32'h100, 32'h0, 5'd4, 1'b0);
      #1;
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL flush_busy got=%b want=0", busy); end
      step();
      total++;
      if ({bus_req_, mem_en, mem_gpr_we_, mem_out} !== {1'b1, 1'b0, 1'b1, 32'h0}) begin
         bad++; $display("FAIL flush_result req_=%b en=%b we_=%b out=%h want 1/0/1/0",
                         bus_req_, mem_en, mem_gpr_we_, mem_out);
      end
      flush = 1'b0; set_nop(32'h0);
   endtask

   task automatic test_reset_mid();
      step();
      bus_grnt_ = 1'b0; bus_rdy_ = 1'b1;
      set_op(2'd1, 32'h100, 32'h0, 5'd2, 1'b0);
      step(); step();
      total++;
      if ({bus_req_, bus_as_} !== 2'b00) begin
         bad++; $display("FAIL rstmid_access req_=%b as_=%b want 0/0", bus_req_, bus_as_);
      end
      reset = 1'b1; set_nop(32'h0);
      step();
      total++;
      if ({bus_req_, bus_as_, bus_addr, mem_en} !== {1'b1, 1'b1, 30'h0, 1'b0}) begin
         bad++; $display("FAIL rstmid_release req_=%b as_=%b addr=%h en=%b want 1/1/0/0",
                         bus_req_, bus_as_, bus_addr, mem_en);
      end
      reset = 1'b0; bus_grnt_ = 1'b1; bus_rdy_ = 1'b0;
      step();
      bus_rdy_ = 1'b1;
      #1;
      total++;
      if ({bus_req_, busy} !== 2'b10) begin
         bad++; $display("FAIL rstmid_idle req_=%b busy=%b want 1/0", bus_req_, busy);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_back_to_back();
      test_ldw();
      test_stw();
      test_misalign();
      test_stall_complete();
      test_flush();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
